alu_pipe_ctrl: RTL



---
 rtl/alu_pipe_ctrl_if.sv | 47 ++++
 rtl/alu_pipe_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/alu_pipe_ctrl_if.sv
// alu_pipe_ctrl_if
//   Bundles every signal of the alu_pipe_ctrl stage except clk/rst.
//   The signals fall into these groups:
//     - request channel:  flush, in_valid/in_ready, in_a, in_b, in_width, in_saturate
//     - alu bus:          alu_a, alu_b, alu_width, alu_saturate (to alu), alu_c (from alu)
//     - response channel: out_valid/out_ready, out_c, out_width
//     - status:           fifo_count, retire_count
//   Modports:
//     slave  - the pipeline stage (alu_pipe_ctrl)
//     master - the environment: requester, alu and downstream consumer
interface alu_pipe_ctrl_if #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_a;
   logic [31:0]       in_b;
   logic [1:0]        in_width;
   logic              in_saturate;
   logic [31:0]       alu_a;
   logic [31:0]       alu_b;
   logic [1:0]        alu_width;
   logic              alu_saturate;
   logic [31:0]       alu_c;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_c;
   logic [1:0]        out_width;
   logic [CW-1:0]     fifo_count;
   logic [CNT_W-1:0]  retire_count;

   modport slave (
      input  flush, in_valid, in_a, in_b, in_width, in_saturate, alu_c, out_ready,
      output in_ready, alu_a, alu_b, alu_width, alu_saturate,
             out_valid, out_c, out_width, fifo_count, retire_count
   );

   modport master (
      output flush, in_valid, in_a, in_b, in_width, in_saturate, alu_c, out_ready,
      input  in_ready, alu_a, alu_b, alu_width, alu_saturate,
             out_valid, out_c, out_width, fifo_count, retire_count
   );
endinterface

// File: rtl/alu_pipe_ctrl.sv
// alu_pipe_ctrl
//   Registered issue/retire stage around the combinational packed-SIMD adder.
//   A request accepted over in_valid/in_ready is held in the operand register
//   (stage p1) that drives the alu; the alu result is written into a small
//   first-word-fall-through FIFO one cycle later and drained over
//   out_valid/out_ready. Full throughput of one op per cycle, with
//   backpressure from a full FIFO stalling the operand register.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - alu_pipe_ctrl_if.slave: request channel, alu bus, response channel,
//          fifo_count (occupancy 0..DEPTH) and retire_count (wrapping count
//          of results written into the FIFO)
module alu_pipe_ctrl #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic         clk,
   input  logic         rst,
   alu_pipe_ctrl_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic              vld_p1;
   logic [31:0]       a_p1;
   logic [31:0]       b_p1;
   logic [1:0]        width_p1;
   logic              sat_p1;

   logic [31:0]       c_mem [DEPTH];
   logic [1:0]        w_mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic [CNT_W-1:0]  retired;

   logic              accept;
   logic              pop;
   logic              push;
   logic              ready;

   // A pop frees a slot in the same cycle, so a full FIFO still takes a push
   // when it is being drained; that is what keeps the stage bubble-free.
   always_comb begin
      pop    = (count != '0) & bus.out_ready;
      push   = vld_p1 & ((count < FULL_CNT) | pop);
      ready  = ~bus.flush & (~vld_p1 | push);
      accept = bus.in_valid & ready;
   end

   // ---- stage p1: operand register feeding the alu ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
      end else if (bus.flush) begin
         vld_p1 <= 1'b0;
      end else if (accept) begin
         vld_p1 <= 1'b1;
      end else if (push) begin
         vld_p1 <= 1'b0;
      end
   end

   // Operands only move on accept, so the alu inputs are frozen during a stall
   // and across a flush (accept is blocked while flush is high).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_p1     <= '0;
         b_p1     <= '0;
         width_p1 <= '0;
         sat_p1   <= 1'b0;
      end else if (accept) begin
         a_p1     <= bus.in_a;
         b_p1     <= bus.in_b;
         width_p1 <= bus.in_width;
         sat_p1   <= bus.in_saturate;
      end
   end

   // ---- stage p2: result FIFO and retire counter ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         retired <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            c_mem[i] <= '0;
            w_mem[i] <= '0;
         end
      end else if (bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            c_mem[wr_ptr] <= bus.alu_c;
            w_mem[wr_ptr] <= width_p1;
            wr_ptr        <= wr_ptr + AW'(1);
            retired       <= retired + CNT_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign bus.in_ready     = ready;
   assign bus.alu_a        = a_p1;
   assign bus.alu_b        = b_p1;
   assign bus.alu_width    = width_p1;
   assign bus.alu_saturate = sat_p1;
   assign bus.out_valid    = (count != '0);
   assign bus.out_c        = c_mem[rd_ptr];
   assign bus.out_width    = w_mem[rd_ptr];
   assign bus.fifo_count   = count;
   assign bus.retire_count = retired;

endmodule
